// File: rtl/fetch_unit.sv
// Instruction-fetch responder: owns PC and IR, applies the control unit's
// PC-write commands and refills IR over a req/ack memory handshake.
//
// state | meaning
// IDLE  | out of reset, fetch starts on the next edge
// REQ   | mem_req high, waiting for mem_ack to load IR
// HOLD  | IR valid and stable, waiting for a PC-write event
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EscCP,
  input  logic               EscCondCP,
  input  logic [1:0]         FonteCP,
  input  logic               EscLR,
  input  logic               Zero,
  input  logic [PC_W-1:0]    ULA_res,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] IR,
  output logic [3:0]         CodOP,
  output logic               instr_valid,
  output logic               stall,
  output logic               seq_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] ir_nxt;
  logic               valid_nxt;
  logic               err_nxt;
  logic               pc_wr_evt;
  logic               take_src;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_src;

  assign pc_wr_evt = EscCP | EscCondCP;
  assign pc_inc    = PC + 1'b1;
  // A conditional write with Zero low still moves on: it falls through to PC+1.
  assign take_src  = EscCP | (EscCondCP & Zero);

  always_comb begin
    pc_src = PC;
    case (FonteCP)
      2'b00:   pc_src = pc_inc;
      2'b01:   pc_src = ULA_res;
      2'b10:   pc_src = IR[PC_W-1:0];
      default: pc_src = PC;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    ir_nxt    = IR;
    valid_nxt = instr_valid;
    err_nxt   = seq_err;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (pc_wr_evt) err_nxt = 1'b1;
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          valid_nxt = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (pc_wr_evt) begin
          pc_nxt    = take_src ? pc_src : pc_inc;
          valid_nxt = 1'b0;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      PC          <= RESET_PC;
      IR          <= '0;
      instr_valid <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      PC          <= pc_nxt;
      IR          <= ir_nxt;
      instr_valid <= valid_nxt;
      seq_err     <= err_nxt;
    end
  end

  assign mem_req  = (state == ST_REQ);
  assign mem_addr = PC;
  assign CodOP    = IR[INSTR_W-1 -: 4];
  assign stall    = EscLR & ~instr_valid;

endmodule
